// File: rtl/pc_next_unit_if.sv
// Fetch bus between the PC unit (master) and instruction memory (slave).
// Carries the request/response handshake used to fetch one instruction.
interface pc_next_unit_if;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_inst;

  // PC unit side: issues requests, consumes responses.
  modport master (
    output if_req_valid,
    output if_addr,
    input  if_req_ready,
    input  if_rsp_valid,
    input  if_rsp_inst
  );

  // Memory side: accepts requests, returns instructions.
  modport slave (
    input  if_req_valid,
    input  if_addr,
    output if_req_ready,
    output if_rsp_valid,
    output if_rsp_inst
  );
endinterface

// File: rtl/pc_next_unit.sv
// pc_next_unit: owns the architectural PC, fetches one instruction at a
// time over the fetch bus, holds it for execute, and on commit computes
// the next PC as (PCAsrc ? imm : 4) + (PCBsrc ? rs1 : pc).
// Optional feature macro: PC_MISALIGN_CHECK_EN -- when defined, a commit
// to a target with tgt[1:0] != 0 traps into a terminal HALT state; when
// undefined, the low two target bits are cleared and execution continues.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          PCAsrc,
  input  logic          PCBsrc,
  input  logic [31:0]   imm,
  input  logic [31:0]   rs1,
  input  logic          commit,
  pc_next_unit_if.master fetch,
  output logic          inst_valid,
  output logic [31:0]   inst,
  output logic [31:0]   pc,
  output logic [63:0]   instret,
  output logic          halted
);

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EXEC = 3'd3,
    HALT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] instret_q, instret_d;

  logic [31:0] add_a, add_b, sum, tgt;

  // Next-PC adder: carry out is dropped so the target wraps at 2^32, and
  // bit 0 is cleared whenever rs1 is the base (jalr rule).
  always_comb begin
    add_a = PCAsrc ? imm : 32'd4;
    add_b = PCBsrc ? rs1 : pc_q;
    sum   = add_a + add_b;
    tgt   = {sum[31:1], sum[0] & ~PCBsrc};
  end

  // Next-state and datapath update for the fetch/execute loop.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    instret_d = instret_q;
    unique case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (fetch.if_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (fetch.if_rsp_valid) begin
          inst_d  = fetch.if_rsp_inst;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (commit) begin
`ifdef PC_MISALIGN_CHECK_EN
          pc_d = tgt;
          if (tgt[1:0] != 2'b00) begin
            state_d = HALT;
          end else begin
            instret_d = instret_q + 64'd1;
            state_d   = REQ;
          end
`else
          pc_d      = tgt & 32'hFFFF_FFFC;
          instret_d = instret_q + 64'd1;
          state_d   = REQ;
`endif
        end
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  // State and datapath registers; reset restores the architectural start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      instret_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block above.
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      instret_q <= instret_d;
    end
  end

  // Handshake outputs decode registered state only, so no input reaches
  // them combinationally.
  assign fetch.if_req_valid = (state_q == REQ);
  assign fetch.if_addr      = pc_q;
  assign inst_valid         = (state_q == EXEC);
  assign inst               = inst_q;
  assign pc                 = pc_q;
  assign instret            = instret_q;

`ifdef PC_MISALIGN_CHECK_EN
  assign halted = (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Program-counter owner for the single-cycle-issue NPC core, and consumer of the branch-condition outputs `PCAsrc`/`PCBsrc`. It holds the architectural PC and drives instruction fetch over a request/response handshake. It presents the fetched instruction to decode/execute. On commit it computes the next PC as (PCAsrc ? imm : 4) + (PCBsrc ? rs1 : pc) and loops back to fetch.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `PCAsrc` input 1: adder A select; 0 = constant 4, 1 = `imm`.
- `PCBsrc` input 1: adder B select; 0 = current PC, 1 = `rs1`.
- `imm` input 32: immediate from decode.
- `rs1` input 32: register rs1 value.
- `commit` input 1: execute finished current instruction; `PCAsrc`/`PCBsrc`/`imm`/`rs1` are valid this cycle.
- `if_req_valid` output 1: fetch request valid.
- `if_req_ready` input 1: memory accepts the request.
- `if_addr` output 32: fetch address (equals `pc`).
- `if_rsp_valid` input 1: fetch data valid.
- `if_rsp_inst` input 32: fetched instruction.
- `inst_valid` output 1: `inst` holds a live instruction for decode.
- `inst` output 32: latched instruction.
- `pc` output 32: architectural PC of `inst`.
- `instret` output 64: committed-instruction count.
- `halted` output 1: misaligned target trapped (only with `PC_MISALIGN_CHECK_EN`).

## Operation
- States: BOOT, REQ, WAIT, EXEC, HALT. Encode in 3 bits.
- Reset values: state=BOOT, `pc`=`RESET_PC`, `inst`=0, `instret`=0. All of `if_req_valid`, `inst_valid` and `halted` are 0.
- BOOT -> REQ unconditionally on the first clock after reset release.
- REQ: `if_req_valid`=1 and `if_addr`=`pc`. On `if_req_valid & if_req_ready` go to WAIT. Otherwise stay with the address held stable.
- WAIT: on `if_rsp_valid`, latch `if_rsp_inst` into `inst` and go to EXEC. `if_rsp_valid` outside WAIT is ignored.
- EXEC: `inst_valid`=1. On `commit`:
  - Compute `tgt` = A + B in 32 bits, with carry out discarded (wraps at 2^32).
  - If `PCBsrc`=1, force `tgt[0]`=0 (jalr rule).
  - `pc` <= `tgt` and `instret` <= `instret`+1 (64-bit wrap). Go to REQ.
- `commit` outside EXEC is ignored.
- `PCAsrc`/`PCBsrc` = 0/1 is a legal, unused combination. It still computes 4+rs1.
- HALT: terminal. No requests, `inst_valid`=0, `halted`=1. Exits only by reset.
- Asynchronous reset mid-operation (any state) returns immediately to the reset values. An outstanding fetch response arriving afterwards is dropped (BOOT/REQ ignore `if_rsp_valid`).

## Timing
- `if_req_valid` and `inst_valid` are decoded from registered state only. Neither has a combinational path from any input.
- `if_addr`, `pc` and `inst` are registered.
- Minimum per-instruction loop is 3 cycles:
  - cycle t: REQ, accepted;
  - cycle t+1: WAIT, response;
  - cycle t+2: EXEC, commit;
  - cycle t+3: REQ with new PC.
- `commit` may be asserted in the first EXEC cycle. `inst_valid` stays high until the commit edge.
- The next-PC adder is combinational from `commit`-cycle inputs to the `pc` register (one cycle).
- The first fetch request after reset release appears at the second rising edge (after BOOT).

## Configuration
- Macro `PC_MISALIGN_CHECK_EN`.
- Defined:
  - On commit with `tgt[1:0]` != 0 (after the jalr bit-0 clear), go to HALT instead of REQ.
  - `pc` is set to the offending `tgt`.
  - `instret` is not incremented.
  - `halted` is 1 from the next cycle.
- Undefined:
  - `tgt[1:0]` is forced to 2'b00 and execution continues.
  - `halted` is tied to 0 and HALT is unreachable.

## Test plan
- Reset then release, `if_req_ready`=1 -> `if_req_valid` rises in the cycle after BOOT, `if_addr`=32'h8000_0000; all outputs 0 during reset.
- Sequential: PCAsrc=0, PCBsrc=0, commit in EXEC at pc=32'h8000_0000 -> next REQ `if_addr`=32'h8000_0004, `instret`=1; loop length exactly 3 cycles with zero-wait memory.
- Branch/jal: PCAsrc=1, PCBsrc=0, imm=32'hFFFF_FFF8 at pc=32'h8000_0010 -> pc=32'h8000_0008.
- Jalr: PCAsrc=1, PCBsrc=1, rs1=32'h8000_0101, imm=0 -> pc=32'h8000_0100 (bit 0 cleared, aligned).
- Misalign: PCAsrc=1, PCBsrc=0, imm=2 at pc=32'h8000_0000:
  - with `PC_MISALIGN_CHECK_EN` -> `halted`=1, no further `if_req_valid`, `instret` unchanged;
  - without -> pc=32'h8000_0000.
- Backpressure and reset: hold `if_req_ready`=0 for 5 cycles -> `if_addr` stable. Assert `rst_n`=0 while in WAIT, then deliver a stale `if_rsp_valid` after release -> it is ignored and the fetch restarts at `RESET_PC`.
